output_deskew: RTL and testbench
================================

# output_deskew

Realigns a skewed multi-lane stream so that every lane's word for the same wavefront leaves on the same cycle. The input is a LANES-wide bundle in which lane i lags lane 0 by i*delay_depth enabled cycles, as produced by cascaded per-lane delay lines on the array input side. The block sits at the accumulator output and hands an aligned wavefront to the post-processing stage. Lane i is delayed by (LANES-1-i)*delay_depth enabled cycles.

## Interface
- LANES, 4, number of lanes.
- WIDTH, 32, data bits per lane.
- MAX_DEPTH, 128, storage entries per lane; bounds the largest per-lane delay.

- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- en  input  1  advance enable; when low, all state holds.
- delay_depth  input  8  per-stage skew in enabled cycles (Cin/8).
- din  input  LANES*WIDTH  lane i occupies din[i*WIDTH +: WIDTH].
- din_valid  input  LANES  per-lane valid, skewed exactly like the data.
- dout  output  LANES*WIDTH  aligned wavefront.
- dout_valid  output  1  AND of all lane valids at the output register.
- align_err  output  1  sticky misalignment flag; see Configuration.
- cfg_err  output  1  requested skew exceeds storage.

## Operation
- Per-lane required delay: R_i = (LANES-1-i)*delay_depth.
- Effective delay: D_i = min(R_i, MAX_DEPTH).
- cfg_err = 1 while any R_i > MAX_DEPTH. This is a registered compare, updated every clk regardless of en.
- Each lane has a circular buffer of D_i entries, each WIDTH+1 bits (data plus valid), followed by one output register.
- D_i = 0 (always true for lane LANES-1, and for all lanes when delay_depth = 0): the lane is the output register only.
- D_i ≥ 1, on each en cycle:
  - The output register loads mem[ptr_i], then mem[ptr_i] is written with {din_valid[i], din lane i}.
  - ptr_i wraps from D_i-1 to 0.
- Control state machine, states RUN and FLUSH:
  - The block latches delay_depth.
  - RUN → FLUSH on any cycle where the input differs from the latched value.
  - FLUSH lasts one clk, independent of en. In FLUSH it:
    - zeros all pointers,
    - clears every stored valid bit,
    - clears the output-register valids,
    - relatches delay_depth.
  - FLUSH → RUN unconditionally. din accepted during the FLUSH cycle is dropped.
- Stored data bits are not cleared, only valid bits. dout may show stale data while dout_valid = 0.
- dout_valid = AND over lanes of the output-register valid bits.

## Timing
- Reset values:
  - dout = 0, dout_valid = 0, align_err = 0, cfg_err = 0.
  - All pointers = 0, all stored valid bits = 0, FSM = RUN, latched delay_depth = 0.
- Wavefront k enters lane i on enabled cycle k + i*delay_depth.
- All lanes of wavefront k appear on dout after the edge at enabled cycle k + (LANES-1)*delay_depth, i.e. latency 1 + D_i per lane.
- With en held low, dout, dout_valid and the pointers hold.
- A reset asserted mid-stream takes effect immediately (asynchronous) and discards all in-flight wavefronts.
- Output valids stay 0 until each lane's buffer has filled with valid input. There are no spurious valids after reset or FLUSH.

## Configuration
- ALIGN_CHECK_EN defined:
  - align_err sets when the per-lane output valids disagree (OR ≠ AND) on an en cycle in RUN.
  - It then holds until rst_n.
- ALIGN_CHECK_EN undefined: align_err is tied to 0 and the check logic is absent.

## Test plan
- Alignment:
  - Stimulus: LANES=4, delay_depth=3, en=1; wavefront k is driven with lane i = k*16+i, valid on lane i at cycle k+3i, for k=0..9.
  - Response: dout_valid first high after edge 9; dout = {0x03,0x02,0x01,0x00}, then {0x13,…}; 10 consecutive valids; align_err=0.
- Bypass:
  - Stimulus: delay_depth=0, unskewed input.
  - Response: every lane has 1-cycle latency, dout equals din one edge later.
- Stall:
  - Stimulus: delay_depth=2 stream; en=0 for 5 cycles mid-stream.
  - Response: dout and dout_valid frozen for those cycles; after resuming, the sequence continues with no gaps or duplicates.
- Depth change:
  - Stimulus: delay_depth changes 3→2 mid-stream.
  - Response: exactly one FLUSH cycle, dout_valid=0 until the new skew refills (first valid at 1+6 enabled cycles after FLUSH), no align_err.
- Overflow:
  - Stimulus: MAX_DEPTH=8, delay_depth=3 (R_0=9).
  - Response: cfg_err=1 on the next edge; lane 0 delay saturates at 8.
- Misalignment (ALIGN_CHECK_EN):
  - Stimulus: drop din_valid on lane 2 for one wavefront.
  - Response: dout_valid=0 for that wavefront and align_err stays 1 until rst_n is asserted.

Source files
------------

// File: rtl/output_deskew.sv
// rtl/output_deskew.sv - realigns a lane-skewed stream into aligned wavefronts
//
// Lane i is delayed by min((LANES-1-i)*delay_depth, MAX_DEPTH) enabled cycles
// through a per-lane circular buffer, then one output register.
// Optional feature macro: ALIGN_CHECK_EN (enables the sticky align_err check).
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   en           advance enable; all datapath state holds when low
//   delay_depth  per-stage skew in enabled cycles
//   din          LANES*WIDTH input, lane i at din[i*WIDTH +: WIDTH]
//   din_valid    per-lane input valid, skewed like the data
//   dout         aligned wavefront
//   dout_valid   AND of all output-register valids
//   align_err    sticky flag: output valids disagreed (ALIGN_CHECK_EN only)
//   cfg_err      registered flag: requested skew exceeds storage

module output_deskew #(
  parameter int LANES     = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_DEPTH = 128
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [7:0]             delay_depth,
  input  logic [LANES*WIDTH-1:0] din,
  input  logic [LANES-1:0]       din_valid,
  output logic [LANES*WIDTH-1:0] dout,
  output logic                   dout_valid,
  output logic                   align_err,
  output logic                   cfg_err
);

  localparam int PW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       dd_q;
  logic [LANES-1:0] ov;
  logic [31:0]      req_max;

  // Control FSM: any change of delay_depth costs one FLUSH cycle, during
  // which the new value is captured and all in-flight valids are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      dd_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == FLUSH) dd_q <= delay_depth;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (delay_depth != dd_q) state_nxt = FLUSH;
      FLUSH:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Lane 0 carries the largest requirement, so it alone decides cfg_err.
  // Compared against the live input so the flag reacts on the next edge.
  assign req_max = 32'(LANES - 1) * 32'(delay_depth);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else        cfg_err <= (req_max > 32'(MAX_DEPTH));
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [31:0]          req;
    logic [31:0]          eff;
    logic                 bypass;
    logic                 wrap;
    logic [PW-1:0]        ptr;
    logic [WIDTH-1:0]     mem_d [MAX_DEPTH];
    logic [MAX_DEPTH-1:0] mem_v;
    logic [WIDTH-1:0]     out_d;
    logic                 out_v;

    assign req    = 32'(LANES - 1 - i) * 32'(dd_q);
    assign eff    = (req > 32'(MAX_DEPTH)) ? 32'(MAX_DEPTH) : req;
    assign bypass = (eff == 32'd0);
    // >= rather than == keeps the pointer in range even if it were ever
    // left beyond a shrunken depth.
    assign wrap   = (32'(ptr) >= (eff - 32'd1));

    // Valid bits live apart from the data so FLUSH can clear them in one
    // cycle; the data words are never cleared.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ptr   <= '0;
        mem_v <= '0;
        out_d <= '0;
        out_v <= 1'b0;
      end else if (state == FLUSH) begin
        ptr   <= '0;
        mem_v <= '0;
        out_v <= 1'b0;
      end else if (en) begin
        if (bypass) begin
          out_d <= din[i*WIDTH +: WIDTH];
          out_v <= din_valid[i];
        end else begin
          // Read-before-write on the same slot gives exactly eff cycles
          // of storage delay.
          out_d      <= mem_d[ptr];
          out_v      <= mem_v[ptr];
          mem_v[ptr] <= din_valid[i];
          ptr        <= wrap ? '0 : ptr + PW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (state == RUN && en && !bypass) mem_d[ptr] <= din[i*WIDTH +: WIDTH];
    end

    assign dout[i*WIDTH +: WIDTH] = out_d;
    assign ov[i]                  = out_v;
  end

  assign dout_valid = &ov;

`ifdef ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  align_err <= 1'b0;
    else if (state == RUN && en && (|ov != &ov)) align_err <= 1'b1;
  end
`else
  assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_output_deskew.sv
// tb/tb_output_deskew.sv - randomized self-checking bench for output_deskew

module tb_output_deskew;

  localparam int L  = 4;
  localparam int W  = 32;
  localparam int MD = 12;
  localparam int DW = L * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [7:0]    delay_depth;
  logic [DW-1:0] din;
  logic [L-1:0]  din_valid;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          align_err;
  logic          cfg_err;

  output_deskew #(.LANES(L), .WIDTH(W), .MAX_DEPTH(MD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .delay_depth(delay_depth),
    .din(din), .din_valid(din_valid), .dout(dout), .dout_valid(dout_valid),
    .align_err(align_err), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Upstream source: wavefront k reaches lane i on enabled cycle k + i*gen_d.
  logic [W-1:0] wf_d [0:255][0:L-1];
  logic         wf_v [0:255][0:L-1];
  int nwf = 0, gen_c = 0, gen_d = 0;

  // Reference model: each lane outputs what it received D_i enabled cycles
  // ago since the last flush; nothing is valid before that history exists.
  logic [W:0]   hist [0:L-1][0:2047];
  logic [W-1:0] m_od [0:L-1];
  logic         m_ov [0:L-1];
  int m_n, m_dd;
  bit m_flush, m_align, m_cfg;

  function automatic int eff_depth(input int i, input int dd);
    int r;
    r = (L - 1 - i) * dd;
    return (r > MD) ? MD : r;
  endfunction

  task automatic model_reset();
    m_n = 0; m_dd = 0; m_flush = 0; m_align = 0; m_cfg = 0;
    for (int i = 0; i < L; i++) begin
      m_od[i] = '0;
      m_ov[i] = 1'b0;
    end
  endtask

  task automatic model_update();
    bit any_v, all_v;
    int d;
    m_cfg = ((L - 1) * int'(delay_depth)) > MD;
    if (m_flush) begin
      m_flush = 0;
      m_n     = 0;
      m_dd    = int'(delay_depth);
      for (int i = 0; i < L; i++) m_ov[i] = 1'b0;
    end else begin
      if (en) begin
        any_v = 0; all_v = 1;
        for (int i = 0; i < L; i++) begin
          any_v |= m_ov[i];
          all_v &= m_ov[i];
        end
`ifdef ALIGN_CHECK_EN
        if (any_v != all_v) m_align = 1;
`endif
        for (int i = 0; i < L; i++) begin
          if (m_n < 2048) hist[i][m_n] = {din_valid[i], din[i*W +: W]};
          d = eff_depth(i, m_dd);
          if (m_n >= d) {m_ov[i], m_od[i]} = hist[i][m_n - d];
          else m_ov[i] = 1'b0;
        end
        m_n++;
      end
      if (int'(delay_depth) != m_dd) m_flush = 1;
    end
  endtask

  task automatic compare(input string ph);
    bit ev;
    ev = 1;
    for (int i = 0; i < L; i++) ev &= m_ov[i];
    check({ph, "_dout_valid"}, DW'(dout_valid), DW'(ev));
    if (ev)
      for (int i = 0; i < L; i++)
        check($sformatf("%s_lane%0d", ph, i), DW'(dout[i*W +: W]), DW'(m_od[i]));
    check({ph, "_cfg_err"}, DW'(cfg_err), DW'(m_cfg));
    check({ph, "_align_err"}, DW'(align_err), DW'(m_align));
  endtask

  task automatic drive_inputs();
    int k;
    for (int i = 0; i < L; i++) begin
      k = gen_c - i * gen_d;
      if (k >= 0 && k < nwf) begin
        din[i*W +: W] = wf_d[k][i];
        din_valid[i]  = wf_v[k][i];
      end else begin
        din[i*W +: W] = $urandom;
        din_valid[i]  = 1'b0;
      end
    end
  endtask

  task automatic step(input logic e, input string ph);
    en = e;
    drive_inputs();
    @(posedge clk);
    model_update();
    if (e) gen_c++;
    @(negedge clk);
    compare(ph);
  endtask

  task automatic start_stream(input int d, input int n, input int gap_pct);
    bit v;
    for (int k = 0; k < n; k++) begin
      v = ($urandom_range(0, 99) >= gap_pct);
      for (int i = 0; i < L; i++) begin
        wf_d[k][i] = $urandom;
        wf_v[k][i] = v;
      end
    end
    gen_c = 0; gen_d = d; nwf = n;
  endtask

  task automatic set_depth(input int d);
    delay_depth = 8'(d);
    nwf = 0;
    step(1'b0, "setup");
    step(1'b0, "setup");
  endtask

  logic [DW-1:0] exp_wf;
  logic [DW-1:0] held_d;
  logic          held_v;
  int first, cnt;

  initial begin
    rst_n = 1'b0; en = 1'b0; delay_depth = '0; din = '0; din_valid = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_dout", dout, '0);
    check("rst_dout_valid", DW'(dout_valid), '0);
    check("rst_align_err", DW'(align_err), '0);
    check("rst_cfg_err", DW'(cfg_err), '0);
    rst_n = 1'b1;

    // Alignment: lane i of wavefront k carries k*16+i, skew 3.
    set_depth(3);
    for (int k = 0; k < 10; k++)
      for (int i = 0; i < L; i++) begin
        wf_d[k][i] = W'(k * 16 + i);
        wf_v[k][i] = 1'b1;
      end
    gen_c = 0; gen_d = 3; nwf = 10;
    first = -1; cnt = 0;
    for (int s = 0; s < 25; s++) begin
      step(1'b1, "align");
      if (dout_valid) begin
        if (first < 0) begin
          first = s;
          exp_wf = {32'h03, 32'h02, 32'h01, 32'h00};
          check("align_first_wf", dout, exp_wf);
        end
        if (s == first + 1) begin
          exp_wf = {32'h13, 32'h12, 32'h11, 32'h10};
          check("align_second_wf", dout, exp_wf);
        end
        cnt++;
      end
    end
    check("align_first_idx", DW'(first), DW'(9));
    check("align_count", DW'(cnt), DW'(10));
    check("align_no_err", DW'(align_err), '0);

    // Bypass: zero skew, one-cycle latency on every lane.
    set_depth(0);
    start_stream(0, 30, 20);
    for (int s = 0; s < 35; s++) begin
      step(1'b1, "bypass");
      if (s == 0 && wf_v[0][0])
        for (int i = 0; i < L; i++)
          check("bypass_lat1", DW'(dout[i*W +: W]), DW'(wf_d[0][i]));
    end

    // Stall: en low for 5 cycles mid-stream, then random enables.
    set_depth(2);
    start_stream(2, 60, 10);
    for (int s = 0; s < 10; s++) step(1'b1, "stall_pre");
    held_d = dout; held_v = dout_valid;
    for (int s = 0; s < 5; s++) begin
      step(1'b0, "stall");
      check("stall_hold_d", dout, held_d);
      check("stall_hold_v", DW'(dout_valid), DW'(held_v));
    end
    for (int s = 0; s < 60; s++) step(1'($urandom_range(0, 3) != 0), "stall_post");

    // Depth change 3 -> 2 mid-stream; upstream restarts with the new skew.
    set_depth(3);
    start_stream(3, 40, 0);
    for (int s = 0; s < 15; s++) step(1'b1, "chg_pre");
    delay_depth = 8'd2;
    step(1'b1, "chg_detect");
    step(1'b1, "chg_flush");
    check("chg_flush_valid", DW'(dout_valid), '0);
    start_stream(2, 30, 0);
    first = -1;
    for (int s = 0; s < 20; s++) begin
      step(1'b1, "chg_post");
      if (dout_valid && first < 0) first = s;
    end
    check("chg_first_idx", DW'(first), DW'(6));
    check("chg_no_err", DW'(align_err), '0);

    // Overflow: R_0 = 12 is the boundary, R_0 = 15 saturates lane 0 at 12.
    delay_depth = 8'd4;
    step(1'b0, "ovf_b");
    check("ovf_boundary_cfg", DW'(cfg_err), '0);
    step(1'b0, "ovf_b");
    delay_depth = 8'd5;
    step(1'b0, "ovf");
    check("ovf_cfg_err", DW'(cfg_err), DW'(1));
    step(1'b0, "ovf");
    start_stream(5, 30, 0);
    for (int s = 0; s < 40; s++) begin
      step(1'b1, "ovf_run");
      if (s == MD) check("ovf_lane0_sat", DW'(dout[W-1:0]), DW'(wf_d[0][0]));
    end

    // Asynchronous reset mid-stream discards everything immediately.
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_dout", dout, '0);
    compare("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    // Misalignment: lane 2 of wavefront 8 arrives without its valid.
    set_depth(3);
    start_stream(3, 20, 0);
    wf_v[8][2] = 1'b0;
    for (int s = 0; s < 35; s++) begin
      step(1'b1, "mis");
      if (s == 17) check("mis_drop_valid", DW'(dout_valid), '0);
    end
`ifdef ALIGN_CHECK_EN
    check("mis_align_sticky", DW'(align_err), DW'(1));
`else
    check("mis_align_tied", DW'(align_err), '0);
`endif
    rst_n = 1'b0;
    model_reset();
    #1;
    check("final_rst_align", DW'(align_err), '0);
    compare("final_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
